fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the brisc core. Holds the PC and issues word requests to instruction memory, one outstanding at a time. Buffers returned instructions with their PCs in a small queue and presents them to decode/control over a valid/ready handshake. Accepts redirects from branch resolution, which flush the queue and squash any in-flight response.

## Interface
- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- RESET_PC, 32'h0000_1000, first fetch address after reset
- QDEPTH, 2, instruction queue entries (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  ILEN  fetched instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch PC
- instr_valid  out  1  queue head valid toward decode
- instr_ready  in  1  decode consumes head
- instr  out  ILEN  head instruction
- instr_pc  out  XLEN  head PC
- fetch_misaligned  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- FSM states: REQ, WAIT, DROP. Registers: pc, pending_pc, queue, count.
- REQ: imem_req_valid = (count < QDEPTH) && !redirect_valid && !fetch_misaligned; imem_req_addr = pc.
  - req handshake -> pending_pc <= pc, pc <= pc + 4, go WAIT.
  - redirect_valid -> pc <= redirect_pc, stay REQ.
- WAIT: rsp_valid && !redirect_valid -> enqueue {pending_pc, rsp_data}, go REQ.
  - rsp_valid && redirect_valid -> discard response, pc <= redirect_pc, go REQ.
  - redirect_valid only -> pc <= redirect_pc, go DROP.
- DROP: rsp_valid -> discard, go REQ; redirect_valid -> pc <= redirect_pc (last one wins), stay DROP.
- Queue: instr_valid = (count != 0); instr/instr_pc = head. Pop on instr_valid && instr_ready && !redirect_valid.
- Redirect: count <= 0 next cycle, regardless of simultaneous pop or enqueue.
- Simultaneous enqueue and pop: count unchanged.
- Issue rule count < QDEPTH guarantees room for the response; no overflow possible.
- pc + 4 wraps modulo 2^XLEN.

## Timing
- Reset values: state REQ, pc = RESET_PC, count 0, instr_valid 0, imem_req_valid 0 while reset high, fetch_misaligned 0.
- First imem_req_valid: the cycle after reset deasserts.
- Response in cycle N -> instr_valid in N+1 (registered queue, no bypass).
- Next request no earlier than cycle N+1. Peak rate is one instruction per (L+1) cycles for memory latency L.
- Redirect in cycle N -> queue empty and new pc in N+1. First request to redirect_pc in N+1 unless in DROP.
- Reset mid-WAIT: the outstanding response is memory's concern. The fetch unit ignores imem_rsp_valid in REQ.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - redirect_pc[1:0] != 0 sets fetch_misaligned (sticky until reset).
  - Queue flushes and requests stop.
- Not defined:
  - redirect_pc[1:0] forced to 0.
  - fetch_misaligned tied 0.

## Structure
- brisc_pkg gains: RESET_PC default, FETCH_QDEPTH, fetch_state_e {REQ, WAIT, DROP}, fetch_entry_t {pc, instr}.
- Existing ILEN/XLEN are reused from brisc_pkg.
- One sub-module: fetch_queue. A synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head outputs.

## Test plan
- Reset release, imem_req_ready=1, latency 1, instr_ready=1 -> requests at 0x1000, 0x1004, 0x1008. instr_pc follows in order, one every 2 cycles.
- instr_ready=0 -> after QDEPTH=2 enqueues imem_req_valid stays 0. Raising instr_ready resumes requests at 0x1008.
- Redirect to 0x2000 while in WAIT, response 3 cycles later -> that response is dropped, queue empty. Next request addr 0x2000.
- Redirect coincident with rsp_valid and instr pop -> nothing enqueued, count 0, next request 0x2000.
- PC 0xFFFF_FFFC -> following request addr 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x2002 -> fetch_misaligned=1, no further requests until reset. Without the macro -> request to 0x2000.

Source files
------------

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared widths, fetch front-end defaults and the fetch types
// used by fetch_unit and fetch_queue.
package brisc_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // Fetch front-end defaults
  localparam logic [XLEN-1:0] RESET_PC     = 32'h0000_1000;
  localparam int              FETCH_QDEPTH = 2;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // may issue a request
    WAIT = 2'd1,  // one request outstanding, response will be kept
    DROP = 2'd2   // one request outstanding, response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // True when an address sits on a 32-bit word boundary
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetch_entry_t. Flush empties it in
// one cycle and wins over push/pop. The caller never pushes when full and
// never pops when empty. DEPTH must be a power of two so pointers wrap.
module fetch_queue
  import brisc_pkg::*;
#(
  parameter int DEPTH = FETCH_QDEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  // Pointer and occupancy bookkeeping; flush restarts the FIFO empty
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents of empty slots are don't-care so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: brisc instruction fetch front end. Holds the PC, keeps at most
// one instruction-memory request in flight, queues returned instructions with
// their PCs and hands them to decode over valid/ready. Redirects flush the
// queue and squash any in-flight response.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a redirect to a non-word
// aligned PC raises sticky fetch_misaligned and halts fetch until reset.
// Without it the low two redirect bits are ignored.
module fetch_unit #(
  parameter int                 XLEN     = brisc_pkg::XLEN,
  parameter int                 ILEN     = brisc_pkg::ILEN,
  parameter logic [XLEN-1:0]    RESET_PC = brisc_pkg::RESET_PC,
  parameter int                 QDEPTH   = brisc_pkg::FETCH_QDEPTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [ILEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic             fetch_misaligned
);

  import brisc_pkg::*;

  localparam int              CW      = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]   Q_FULL  = CW'(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] pending_pc_r;
  logic [XLEN-1:0] pending_pc_s;
  logic [XLEN-1:0] redirect_target_s;
  logic            req_valid_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   q_count_s;
  fetch_entry_t    q_head_s;
  fetch_entry_t    push_entry_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_r;

  assign redirect_target_s = redirect_pc;

  // Sticky misaligned-redirect flag; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_r <= 1'b0;
    end else if (redirect_valid && !is_word_aligned(redirect_pc)) begin
      misaligned_r <= 1'b1;
    end
  end

  assign fetch_misaligned = misaligned_r;
`else
  logic unused_redirect_low_s;

  // Low bits are meaningless for word fetch; drop them
  assign redirect_target_s     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_low_s = ^redirect_pc[1:0];
  assign fetch_misaligned      = 1'b0;
`endif

  // FSM and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= REQ;
      pc_r         <= RESET_PC;
      pending_pc_r <= RESET_PC;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      pending_pc_r <= pending_pc_s;
    end
  end

  // Next-state, PC update, request issue and enqueue decision
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    pending_pc_s = pending_pc_r;
    req_valid_s  = 1'b0;
    push_s       = 1'b0;
    case (state_r)
      REQ: begin
        req_valid_s = !reset && (q_count_s < Q_FULL) && !redirect_valid &&
                      !fetch_misaligned;
        if (redirect_valid) begin
          pc_s = redirect_target_s;
        end else if (req_valid_s && imem_req_ready) begin
          pending_pc_s = pc_r;
          pc_s         = pc_r + PC_STEP;
          state_s      = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rsp_valid && redirect_valid) begin
          pc_s    = redirect_target_s;
          state_s = REQ;
        end else if (imem_rsp_valid) begin
          push_s  = 1'b1;
          state_s = REQ;
        end else if (redirect_valid) begin
          pc_s    = redirect_target_s;
          state_s = DROP;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_s = redirect_target_s;
        end else begin
          pc_s = pc_r;
        end
        if (imem_rsp_valid) begin
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = REQ;
      end
    endcase
  end

  assign pop_s              = instr_valid && instr_ready && !redirect_valid;
  assign push_entry_s.pc    = pending_pc_r;
  assign push_entry_s.instr = imem_rsp_data;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .count      (q_count_s),
    .head       (q_head_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign instr_valid    = (q_count_s != '0);
  assign instr          = q_head_s.instr;
  assign instr_pc       = q_head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle bench for fetch_unit with
// hand-computed expectations. Inputs change 1 ns after each rising edge and
// outputs are compared a further 1 ns later, well before the next edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    // Reset held
    tick();
    tick();
    settle();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);

    // A: reset released, first request at RESET_PC
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    settle();
    chk("a_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("a_req_addr", imem_req_addr, 32'h0000_1000);
    tick();

    // B: latency-1 response, no new request while waiting
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_0000;
    settle();
    chk("b_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("b_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();

    // C: instruction visible one cycle after response, next request 0x1004
    imem_rsp_valid = 1'b0;
    settle();
    chk("c_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("c_instr_pc", instr_pc, 32'h0000_1000);
    chk("c_instr", instr, 32'hAAAA_0000);
    chk("c_req_addr", imem_req_addr, 32'h0000_1004);
    chk("c_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();

    // D: head consumed, response for 0x1004
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_0004;
    settle();
    chk("d_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();

    // E: decode stalls from here on; request 0x1008 still issues
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    settle();
    chk("e_instr_pc", instr_pc, 32'h0000_1004);
    chk("e_instr", instr, 32'hAAAA_0004);
    chk("e_req_addr", imem_req_addr, 32'h0000_1008);
    tick();

    // F: response for 0x1008 fills the queue
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_0008;
    tick();

    // G: queue full, requests stop
    imem_rsp_valid = 1'b0;
    settle();
    chk("g_full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("g_head_pc", instr_pc, 32'h0000_1004);
    tick();

    // H: decode resumes; still full this cycle
    instr_ready = 1'b1;
    settle();
    chk("h_full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("h_head_pc", instr_pc, 32'h0000_1004);
    tick();

    // I: one slot free, requests resume at 0x100C
    settle();
    chk("i_head_pc", instr_pc, 32'h0000_1008);
    chk("i_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("i_req_addr", imem_req_addr, 32'h0000_100C);
    tick();

    // J: redirect while waiting on 0x100C
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    settle();
    chk("j_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // K, L: draining the squashed response, no requests
    redirect_valid = 1'b0;
    settle();
    chk("k_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("k_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    settle();
    chk("l_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // M: late response arrives and is discarded
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    settle();
    chk("m_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // N: queue still empty, fetch restarts at 0x2000
    imem_rsp_valid = 1'b0;
    settle();
    chk("n_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("n_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("n_req_addr", imem_req_addr, 32'h0000_2000);
    tick();

    // O: response for 0x2000
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBBBB_2000;
    tick();

    // P: hold head, request 0x2004
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    settle();
    chk("p_instr_pc", instr_pc, 32'h0000_2000);
    chk("p_instr", instr, 32'hBBBB_2000);
    chk("p_req_addr", imem_req_addr, 32'h0000_2004);
    tick();

    // Q: redirect coincides with response and pop attempt
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBBBB_2004;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    instr_ready    = 1'b1;
    settle();
    chk("q_instr_valid", {31'd0, instr_valid}, 32'd1);
    tick();

    // R: nothing enqueued, next request 0x2000; then redirect near the top
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    settle();
    chk("r_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("r_req_addr", imem_req_addr, 32'h0000_2000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    settle();
    chk("r_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // S: request at 0xFFFF_FFFC
    redirect_valid = 1'b0;
    settle();
    chk("s_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("s_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();

    // T: response
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCCCC_FFFC;
    tick();

    // U: PC wrapped to zero; memory not ready so nothing issues
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    settle();
    chk("u_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("u_req_addr_wrap", imem_req_addr, 32'h0000_0000);
    chk("u_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();

    // V: redirect to a misaligned PC
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    settle();
    chk("v_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // W: outcome depends on alignment checking
    redirect_valid = 1'b0;
    settle();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("w_misaligned", {31'd0, fetch_misaligned}, 32'd1);
    chk("w_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    settle();
    chk("w2_misaligned", {31'd0, fetch_misaligned}, 32'd1);
    chk("w2_req_valid", {31'd0, imem_req_valid}, 32'd0);
`else
    chk("w_misaligned", {31'd0, fetch_misaligned}, 32'd0);
    chk("w_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("w_req_addr", imem_req_addr, 32'h0000_2000);
`endif
    tick();

    // Reset again: flag cleared, fetch restarts at RESET_PC
    reset = 1'b1;
    tick();
    settle();
    chk("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b0;
    settle();
    chk("rst2_misaligned", {31'd0, fetch_misaligned}, 32'd0);
    chk("rst2_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
    chk("rst2_req_addr", imem_req_addr, 32'h0000_1000);
    chk("rst2_instr_valid", {31'd0, instr_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
